// File: rtl/usd_pkg.sv
// usd_pkg: shared definitions for the ultrasonic scan scheduler.
//   - FSM state encoding
//   - distance width and the special response codes
//   - 50 MHz cycle constants for the default timing
package usd_pkg;

    localparam int          DIST_W       = 16;
    localparam logic [15:0] NO_ECHO_CODE = 16'h2709;  // first "no obstacle" code
    localparam logic [15:0] DIST_MAX     = 16'h2710;  // interface timeout / reset distance
    localparam logic [15:0] DIST_NONE    = 16'hFFFF;  // nearest value when nothing was seen

    localparam int CYC_10US = 500;
    localparam int CYC_10MS = 500_000;
    localparam int CYC_25MS = 1_250_000;

    localparam int CNT_W       = 24;
    // Cycles spent in SAMPLE before the result is stored, so the
    // interface has re-armed after its trigger fell.
    localparam int SAMPLE_WAIT = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_PING,
        S_SAMPLE,
        S_GAP
    } state_t;

endpackage

// File: rtl/usd_next_index.sv
// usd_next_index: combinational priority search over a sensor mask.
//   i_mask   in   NUM_SENSORS  candidate sensors
//   i_idx    in   IDX_W        reference index
//   i_above  in   1            1 = only bits strictly above i_idx, 0 = i_idx and above
//   o_idx    out  IDX_W        lowest matching set bit
//   o_none   out  1            no matching bit (o_idx is 0)
module usd_next_index #(
    parameter int NUM_SENSORS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_SENSORS-1:0] i_mask,
    input  logic [IDX_W-1:0]       i_idx,
    input  logic                   i_above,
    output logic [IDX_W-1:0]       o_idx,
    output logic                   o_none
);

    // Scan downwards so the lowest qualifying bit is the last one written.
    always_comb begin
        o_idx  = '0;
        o_none = 1'b1;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (i_mask[i] && ((i > int'(i_idx)) || (!i_above && (i == int'(i_idx))))) begin
                o_idx  = IDX_W'(i);
                o_none = 1'b0;
            end
        end
    end

endmodule

// File: rtl/usd_scan_scheduler.sv
// usd_scan_scheduler: runs a bank of ultrasonic sensor interfaces one at a
// time so their echoes never overlap, and reports per-sensor distances plus
// the nearest obstacle of each completed scan.
//   clk_50mhz         in   system clock
//   reset_n           in   asynchronous active-low reset
//   scan_enable       in   level, 1 = scan continuously
//   scan_mask         in   sensors included in a scan (sampled at scan start)
//   sensor_response   in   per-sensor latched distance, sensor i at [16i+:16]
//   sensor_trigger    out  one-hot (or zero) trigger to the interfaces
//   distance          out  last stored result per sensor
//   sample_valid      out  1-cycle pulse when a distance is stored
//   sample_index      out  sensor just stored
//   nearest_distance  out  minimum valid distance of the last completed scan
//   nearest_index     out  sensor that produced it
//   nearest_valid     out  last completed scan saw an echo below NO_ECHO
//   scan_done         out  1-cycle pulse at the end of each completed scan
//   busy              out  FSM is not idle
// Per-sensor timeline: ARM (1) -> PING (WINDOW_CYCLES, trigger high) ->
// SAMPLE (SAMPLE_WAIT wait cycles + store cycle) -> GAP (GAP_CYCLES).
module usd_scan_scheduler
    import usd_pkg::*;
#(
    parameter int          NUM_SENSORS   = 4,
    parameter int          IDX_W         = 2,
    parameter int          WINDOW_CYCLES = CYC_25MS,
    parameter int          GAP_CYCLES    = CYC_10MS,
    parameter logic [15:0] NO_ECHO       = NO_ECHO_CODE
) (
    input  logic                          clk_50mhz,
    input  logic                          reset_n,
    input  logic                          scan_enable,
    input  logic [NUM_SENSORS-1:0]        scan_mask,
    input  logic [DIST_W*NUM_SENSORS-1:0] sensor_response,
    output logic [NUM_SENSORS-1:0]        sensor_trigger,
    output logic [DIST_W*NUM_SENSORS-1:0] distance,
    output logic                          sample_valid,
    output logic [IDX_W-1:0]              sample_index,
    output logic [DIST_W-1:0]             nearest_distance,
    output logic [IDX_W-1:0]              nearest_index,
    output logic                          nearest_valid,
    output logic                          scan_done,
    output logic                          busy
);

    localparam logic [CNT_W-1:0]       WIN_LAST = CNT_W'(WINDOW_CYCLES - 1);
    localparam logic [CNT_W-1:0]       GAP_LAST = CNT_W'(GAP_CYCLES - 1);
    localparam logic [CNT_W-1:0]       SMP_LAST = CNT_W'(SAMPLE_WAIT);
    localparam logic [NUM_SENSORS-1:0] ONE_HOT  = NUM_SENSORS'(1);

    state_t                          r_state;
    logic [CNT_W-1:0]                r_cnt;
    logic [NUM_SENSORS-1:0]          r_mask;
    logic [IDX_W-1:0]                r_idx;
    logic [DIST_W-1:0]               r_min;
    logic [IDX_W-1:0]                r_min_idx;
    logic [NUM_SENSORS-1:0]          r_trig;
    logic [DIST_W*NUM_SENSORS-1:0]   r_dist;
    logic                            r_sample_valid;
    logic [IDX_W-1:0]                r_sample_index;
    logic [DIST_W-1:0]               r_nearest_dist;
    logic [IDX_W-1:0]                r_nearest_idx;
    logic                            r_nearest_valid;
    logic                            r_scan_done;

    logic [IDX_W-1:0]  w_first_idx;
    logic              w_first_none;
    logic [IDX_W-1:0]  w_next_idx;
    logic              w_next_none;
    logic              w_start;
    logic [DIST_W-1:0] w_resp_sel;

    // Lowest set bit of the live mask, used when a scan starts.
    usd_next_index #(.NUM_SENSORS(NUM_SENSORS), .IDX_W(IDX_W)) u_first (
        .i_mask  (scan_mask),
        .i_idx   ('0),
        .i_above (1'b0),
        .o_idx   (w_first_idx),
        .o_none  (w_first_none)
    );

    // Next captured-mask bit after the sensor currently being served.
    usd_next_index #(.NUM_SENSORS(NUM_SENSORS), .IDX_W(IDX_W)) u_next (
        .i_mask  (r_mask),
        .i_idx   (r_idx),
        .i_above (1'b1),
        .o_idx   (w_next_idx),
        .o_none  (w_next_none)
    );

    assign w_start    = scan_enable && !w_first_none;
    assign w_resp_sel = sensor_response[int'(r_idx)*DIST_W +: DIST_W];

    // Trigger is a register with async clear, so it falls with reset_n,
    // not at the next clock edge.
    always_ff @(posedge clk_50mhz or negedge reset_n) begin
        if (!reset_n) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_mask          <= '0;
            r_idx           <= '0;
            r_min           <= DIST_NONE;
            r_min_idx       <= '0;
            r_trig          <= '0;
            r_dist          <= {NUM_SENSORS{DIST_MAX}};
            r_sample_valid  <= 1'b0;
            r_sample_index  <= '0;
            r_nearest_dist  <= DIST_NONE;
            r_nearest_idx   <= '0;
            r_nearest_valid <= 1'b0;
            r_scan_done     <= 1'b0;
        end else begin
            r_sample_valid <= 1'b0;
            r_scan_done    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_start) begin
                        r_mask    <= scan_mask;
                        r_min     <= DIST_NONE;
                        r_min_idx <= '0;
                        r_idx     <= w_first_idx;
                        r_state   <= S_ARM;
                    end
                end
                S_ARM: begin
                    r_cnt   <= '0;
                    r_trig  <= ONE_HOT << r_idx;
                    r_state <= S_PING;
                end
                S_PING: begin
                    if (r_cnt == WIN_LAST) begin
                        r_trig  <= '0;
                        r_cnt   <= '0;
                        r_state <= S_SAMPLE;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_SAMPLE: begin
                    if (r_cnt == SMP_LAST) begin
                        r_dist[int'(r_idx)*DIST_W +: DIST_W] <= w_resp_sel;
                        r_sample_valid <= 1'b1;
                        r_sample_index <= r_idx;
                        // Strict compare: on a tie the earlier (lower) index stays.
                        if ((w_resp_sel < NO_ECHO) && (w_resp_sel < r_min)) begin
                            r_min     <= w_resp_sel;
                            r_min_idx <= r_idx;
                        end
                        r_cnt   <= '0;
                        r_state <= S_GAP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt <= '0;
                        if (!w_next_none) begin
                            // Sensors left: continue, or abort quietly if disabled.
                            if (scan_enable) begin
                                r_idx   <= w_next_idx;
                                r_state <= S_ARM;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end else begin
                            r_nearest_dist  <= r_min;
                            r_nearest_idx   <= r_min_idx;
                            r_nearest_valid <= (r_min != DIST_NONE);
                            r_scan_done     <= 1'b1;
                            if (w_start) begin
                                r_mask    <= scan_mask;
                                r_min     <= DIST_NONE;
                                r_min_idx <= '0;
                                r_idx     <= w_first_idx;
                                r_state   <= S_ARM;
                            end else begin
                                r_state <= S_IDLE;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign sensor_trigger   = r_trig;
    assign distance         = r_dist;
    assign sample_valid     = r_sample_valid;
    assign sample_index     = r_sample_index;
    assign nearest_distance = r_nearest_dist;
    assign nearest_index    = r_nearest_idx;
    assign nearest_valid    = r_nearest_valid;
    assign scan_done        = r_scan_done;
    assign busy             = (r_state != S_IDLE);

endmodule
